// File: rtl/mul_div_unit_pkg.sv
// Shared RV32M multiply/divide definitions: funct3 encodings, FSM states, counter sizing.
// No logic; imported by mul_div_unit.
package mul_div_unit_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must hold the value WIDTH itself, which marks the finalize cycle.
    function automatic int iter_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, on shared accumulator.
// Latency: 33 cycles accept-to-done for every funct3, special cases included.
// Backpressure: start_i ignored while busy_o; accept allowed in the done cycle's successor.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] rs1_data_i,
    input  logic [WIDTH-1:0] rs2_data_i,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int                CNT_W     = iter_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0]  ITER_LAST = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0]  MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         f3_q;
    logic               sign_a;
    logic               sign_b;
    logic               div_zero;
    logic               div_ovf;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] acc;

    logic               accept;
    logic               in_sa;
    logic               in_sb;
    logic               in_dz;
    logic               in_ovf;
    logic [WIDTH-1:0]   in_a_mag;
    logic [WIDTH-1:0]   in_b_mag;

    assign accept = start_i && (state != ST_CALC);

    always_comb begin
        in_sa    = rs1_data_i[WIDTH-1] && (funct3_i == F3_MULH || funct3_i == F3_MULHSU ||
                                           funct3_i == F3_DIV  || funct3_i == F3_REM);
        in_sb    = rs2_data_i[WIDTH-1] && (funct3_i == F3_MULH || funct3_i == F3_DIV ||
                                           funct3_i == F3_REM);
        in_a_mag = in_sa ? -rs1_data_i : rs1_data_i;
        in_b_mag = in_sb ? -rs2_data_i : rs2_data_i;
        in_dz    = funct3_i[2] && (rs2_data_i == '0);
        in_ovf   = (funct3_i == F3_DIV || funct3_i == F3_REM) &&
                   (rs1_data_i == MIN_NEG) && (rs2_data_i == '1);
    end

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_nx;
    logic               q_bit;
    logic [2*WIDTH-1:0] acc_step;

    // Multiply: acc = {partial, multiplier}, shifted right each step.
    // Divide:   acc = {remainder, dividend/quotient}, shifted left each step.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        q_bit    = (rem_sh >= {1'b0, b_mag});
        rem_nx   = q_bit ? WIDTH'(rem_sh - {1'b0, b_mag}) : rem_sh[WIDTH-1:0];
        acc_step = f3_q[2] ? {rem_nx, acc[WIDTH-2:0], q_bit}
                           : {mul_sum, acc[WIDTH-1:1]};
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rmd;
    logic [WIDTH-1:0]   rs1_rec;
    logic [WIDTH-1:0]   fin;

    always_comb begin
        prod    = (sign_a ^ sign_b) ? -acc : acc;
        quo     = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rmd     = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        rs1_rec = sign_a ? -a_mag : a_mag;
        fin     = '0;
        case (f3_q)
            F3_MUL:                       fin = prod[WIDTH-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fin = prod[2*WIDTH-1:WIDTH];
            F3_DIV, F3_DIVU:              fin = div_zero ? '1 : (div_ovf ? MIN_NEG : quo);
            default:                      fin = div_zero ? rs1_rec : (div_ovf ? '0 : rmd);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            f3_q     <= F3_MUL;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
            a_mag    <= '0;
            b_mag    <= '0;
            acc      <= '0;
            result_o <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else if (accept) begin
            state    <= ST_CALC;
            cnt      <= '0;
            f3_q     <= funct3_i;
            sign_a   <= in_sa;
            sign_b   <= in_sb;
            div_zero <= in_dz;
            div_ovf  <= in_ovf;
            a_mag    <= in_a_mag;
            b_mag    <= in_b_mag;
            acc      <= funct3_i[2] ? {{WIDTH{1'b0}}, in_a_mag} : {{WIDTH{1'b0}}, in_b_mag};
            busy_o   <= 1'b1;
            done_o   <= 1'b0;
        end else begin
            case (state)
                ST_CALC: begin
                    if (cnt == ITER_LAST) begin
                        result_o <= fin;
                        state    <= ST_DONE;
                        busy_o   <= 1'b0;
                        done_o   <= 1'b1;
                    end else begin
                        acc <= acc_step;
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    done_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed bench for mul_div_unit against a plain-arithmetic RV32M model.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  funct3_i = 3'd0;
    logic [31:0] rs1_data_i = 32'd0;
    logic [31:0] rs2_data_i = 32'd0;
    logic [31:0] result_o;
    logic        busy_o;
    logic        done_o;

    int tests = 0;
    int fails = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_i),
        .funct3_i   (funct3_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .result_o   (result_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RV32M semantics straight from the ISA rules, using 64-bit arithmetic.
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        longint      p;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        pu = {32'd0, a} * {32'd0, b};
        case (f)
            3'd0: return pu[31:0];
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: return pu[63:32];
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Behavioural model: an operation accepted when idle completes 33 edges later.
    logic        busy_e = 1'b0;
    logic        done_e = 1'b0;
    logic [31:0] res_e = 32'd0;
    logic [31:0] pend = 32'd0;
    int          cnt_e = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_e = 1'b0;
            done_e = 1'b0;
            res_e  = 32'd0;
            cnt_e  = 0;
        end else begin
            done_e = 1'b0;
            if (busy_e) begin
                cnt_e++;
                if (cnt_e == 33) begin
                    busy_e = 1'b0;
                    done_e = 1'b1;
                    res_e  = pend;
                end
            end else if (start_i) begin
                busy_e = 1'b1;
                cnt_e  = 0;
                pend   = ref_op(funct3_i, rs1_data_i, rs2_data_i);
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            check("busy", {31'd0, busy_o}, {31'd0, busy_e});
            check("done", {31'd0, done_o}, {31'd0, done_e});
            if (done_e) check("result", result_o, res_e);
        end
    end

    // Issue one op; optionally pulse start_i at iteration 'poke'. Returns latency and result.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int poke, output logic [31:0] res, output int lat);
        @(negedge clk);
        start_i = 1'b1; funct3_i = f; rs1_data_i = a; rs2_data_i = b;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0; rs1_data_i = $urandom; rs2_data_i = $urandom;
        lat = 0;
        res = 32'd0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done_o) begin
                lat = k;
                res = result_o;
                break;
            end
            start_i = (k == poke);
            if (k == poke) begin
                funct3_i = 3'd0; rs1_data_i = 32'd1; rs2_data_i = 32'd1;
            end
        end
        start_i = 1'b0;
    endtask

    task automatic directed(input string name, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp, input int poke);
        logic [31:0] res;
        int          lat;
        check({name, "_model"}, ref_op(f, a, b), exp);
        do_op(f, a, b, poke, res, lat);
        check(name, res, exp);
        check({name, "_latency"}, 32'(lat), 32'd33);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

    initial begin
        logic [31:0] res;
        int          lat;
        int          done_t[$];

        repeat (3) @(posedge clk);
        #1;
        check("reset_result", result_o, 32'd0);
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        check("reset_done", {31'd0, done_o}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        directed("mul_7_m3",      3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        directed("mulh_min",      3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0);
        directed("mulhu_ones",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        directed("mulhsu_ones",   3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        directed("div_m7_2",      3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0);
        directed("rem_m7_2",      3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 0);
        directed("divu_7_2",      3'd5, 32'd7,          32'd2,         32'd3,         0);
        directed("remu_7_2",      3'd7, 32'd7,          32'd2,         32'd1,         0);
        directed("div_by_zero",   3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 0);
        directed("remu_by_zero",  3'd7, 32'd5,          32'd0,         32'd5,         0);
        directed("div_overflow",  3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
        directed("rem_overflow",  3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0);
        directed("rem_by_zero_n", 3'd6, 32'hFFFF_FFF0,  32'd0,         32'hFFFF_FFF0, 0);
        directed("start_ignored", 3'd5, 32'd100,        32'd7,         32'd14,        10);

        // Reset in the middle of a calculation.
        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'd6; rs1_data_i = 32'd1234; rs2_data_i = 32'd10;
        @(negedge clk);
        start_i = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midreset_busy", {31'd0, busy_o}, 32'd0);
        check("midreset_done", {31'd0, done_o}, 32'd0);
        check("midreset_result", result_o, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        directed("after_reset", 3'd4, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 0);

        // start_i held high with operands changing every cycle.
        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'($urandom); rs1_data_i = pick(); rs2_data_i = pick();
        for (int t = 0; t <= 105; t++) begin
            @(posedge clk);
            #1;
            if (done_o) done_t.push_back(t);
            funct3_i = 3'($urandom); rs1_data_i = pick(); rs2_data_i = pick();
            if (t >= 101) start_i = 1'b0;
        end
        check("b2b_count", 32'(done_t.size()), 32'd3);
        if (done_t.size() == 3) begin
            check("b2b_done0", 32'(done_t[0]), 32'd33);
            check("b2b_done1", 32'(done_t[1]), 32'd67);
            check("b2b_done2", 32'(done_t[2]), 32'd101);
        end

        for (int n = 0; n < 150; n++) begin
            do_op(3'($urandom), pick(), pick(), 0, res, lat);
            check("rand_latency", 32'(lat), 32'd33);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative RV32M multiply/divide unit. It sits in the execute stage beside the ALU and downstream of the ALU control decode. It consumes funct3 and the two register operands when the M-extension path is selected, and returns a 32-bit result after a fixed latency. The pipeline is stalled on busy_o.

## Interface
- WIDTH, 32: operand and result width.
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset. Asserts immediately; deasserts synchronously to clk in the surrounding design.
- start_i  input  1  request. Accepted on a posedge where start_i=1 and busy_o=0.
- funct3_i  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_data_i  input  WIDTH  dividend / multiplicand.
- rs2_data_i  input  WIDTH  divisor / multiplier.
- result_o  output  WIDTH  registered result. Valid while done_o=1; held until the next accept.
- busy_o  output  1  operation in progress.
- done_o  output  1  one-cycle completion pulse.

## Operation
- States: IDLE, CALC, DONE.
  - IDLE→CALC on accept.
  - CALC→DONE when the iteration count reaches WIDTH.
  - DONE→CALC on accept; otherwise DONE→IDLE.
- On accept, the unit captures:
  - funct3
  - operand signs: signed for MULH/DIV/REM; rs1 only for MULHSU; none for MULHU/DIVU/REMU/MUL
  - magnitudes |rs1|, |rs2|
  - special-case flags: divisor==0; signed overflow (rs1=0x8000_0000 and rs2=0xFFFF_FFFF with DIV/REM)
- Iteration counter runs 0..WIDTH-1, one step per CALC cycle.
- Multiply: shift-add on magnitudes into a 2*WIDTH accumulator.
  - Final negate if the operand signs differ.
  - MUL returns the low word; MULH/MULHSU/MULHU return the high word.
- Divide: restoring shift-subtract on magnitudes.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Special cases override the datapath result on the DONE transition. Total latency does not change.
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return rs1.
  - Overflow: DIV returns 0x8000_0000; REM returns 0.
- start_i while busy_o=1 is ignored. Operand changes during CALC have no effect.
- Reset, at any time including mid-CALC: state IDLE, counter 0, result_o=0, busy_o=0, done_o=0.

## Timing
- Accept edge E0.
- busy_o=1 from after E0 until E33.
- Iterations occur on E1..E32.
- At E33: result_o is loaded, done_o=1, busy_o=0.
- At E34: done_o=0. An accept is allowed on E34, giving zero dead cycles for back-to-back operations.
- Latency from accept to done is 33 cycles for every funct3, including special cases.
- busy_o and done_o are never 1 in the same cycle.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared definitions file holds:
  - funct3 encodings as localparams (MUL..REMU)
  - state encoding (IDLE/CALC/DONE)
  - iteration count constant derived from WIDTH
- Single module, no sub-modules. The multiply and divide datapaths share the accumulator and counter registers.

## Test plan
- MUL 7 × 0xFFFF_FFFD (-3): result_o=0xFFFF_FFEB, done_o exactly at E33, busy_o high E1..E32.
- High-word multiplies:
  - MULH 0x8000_0000 × 0x8000_0000 → 0x4000_0000
  - MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE
  - MULHSU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFF
- Divide and remainder:
  - DIV 0xFFFF_FFF9 (-7) / 2 → 0xFFFF_FFFD
  - REM same operands → 0xFFFF_FFFF
  - DIVU 7/2 → 3
  - REMU 7/2 → 1
- Special cases, each with latency still 33:
  - DIV 5/0 → 0xFFFF_FFFF
  - REMU 5/0 → 5
  - DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000
  - REM same operands → 0
- Protocol and reset:
  - start_i pulsed at iteration 10 is ignored, and the result is unchanged.
  - reset driven low at iteration 10 forces busy_o/done_o/result_o to 0 immediately.
  - The next accept completes correctly.
- start_i held high continuously with changing operands: accepts at E0, E34, E68. done_o pulses at E33, E67, E101, each with the matching result.
